// File: rtl/inst_encoder_writer_if.sv
// Field-input handshake and instruction-memory write bundle for inst_encoder_writer.
interface inst_encoder_writer_if #(
    parameter int DEPTH  = 4,
    parameter int MEM_AW = 10
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic              in_valid;
    logic              in_ready;
    logic              form;
    logic [2:0]        opcode;
    logic [4:0]        reg_addr_0;
    logic [4:0]        reg_addr_1;
    logic [4:0]        reg_addr_2;
    logic [14:0]       addr;
    logic              load_base;
    logic [MEM_AW-1:0] base_addr;
    logic              mem_we;
    logic [MEM_AW-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_ack;
    logic [CW-1:0]     fifo_count;
    logic [15:0]       words_written;
    logic              form_err;

    modport slave (
        input  in_valid, form, opcode, reg_addr_0, reg_addr_1, reg_addr_2, addr,
               load_base, base_addr, mem_ack,
        output in_ready, mem_we, mem_addr, mem_wdata, fifo_count, words_written, form_err
    );

    modport master (
        output in_valid, form, opcode, reg_addr_0, reg_addr_1, reg_addr_2, addr,
               load_base, base_addr, mem_ack,
        input  in_ready, mem_we, mem_addr, mem_wdata, fifo_count, words_written, form_err
    );
endinterface

// File: rtl/inst_encoder_writer.sv
// Packs instruction fields into 32-bit words, buffers them in a small FIFO and
// streams them into instruction memory at sequential addresses.
module inst_encoder_writer #(
    parameter int                DEPTH     = 4,
    parameter int                MEM_AW    = 10,
    parameter logic [MEM_AW-1:0] BASE_ADDR = '0
) (
    input logic                  clk,
    input logic                  rst_n,
    inst_encoder_writer_if.slave bus
);
    localparam int            PW   = $clog2(DEPTH);
    localparam int            CW   = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic {S_IDLE, S_WRITE} state_t;

    logic [31:0]       r_mem [DEPTH];
    logic [PW-1:0]     r_wrPtr;
    logic [PW-1:0]     r_rdPtr;
    logic [CW-1:0]     r_count;
    logic              r_formErr;
    state_t            r_state;
    logic              r_memWe;
    logic [31:0]       r_memWdata;
    logic [MEM_AW-1:0] r_memAddr;
    logic [15:0]       r_wordsWritten;

    logic              w_push;
    logic              w_pop;
    logic [PW-1:0]     w_rdNext;
    logic [31:0]       w_encoded;

    assign w_push    = bus.in_valid && (r_count < FULL);
    assign w_pop     = (r_state == S_WRITE) && bus.mem_ack;
    assign w_rdNext  = r_rdPtr + PW'(1);
    assign w_encoded = bus.form
        ? {bus.opcode, bus.reg_addr_0, bus.reg_addr_1, 4'b0, bus.addr}
        : {bus.opcode, bus.reg_addr_0, bus.reg_addr_1, bus.reg_addr_2, 14'b0};

    assign bus.in_ready      = (r_count < FULL);
    assign bus.fifo_count    = r_count;
    assign bus.form_err      = r_formErr;
    assign bus.mem_we        = r_memWe;
    assign bus.mem_wdata     = r_memWdata;
    assign bus.mem_addr      = r_memAddr;
    assign bus.words_written = r_wordsWritten;

    // Storage needs no reset: occupancy is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (rst_n && w_push) begin
            r_mem[r_wrPtr] <= w_encoded;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wrPtr   <= '0;
            r_rdPtr   <= '0;
            r_count   <= '0;
            r_formErr <= 1'b0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + PW'(1);
                if (bus.form && (bus.reg_addr_2 != 5'd0)) begin
                    r_formErr <= 1'b1;
                end
            end
            if (w_pop) begin
                r_rdPtr <= w_rdNext;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

    // The head stays in the FIFO until acked; a second buffered word lets WRITE chain.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state        <= S_IDLE;
            r_memWe        <= 1'b0;
            r_memWdata     <= '0;
            r_memAddr      <= BASE_ADDR;
            r_wordsWritten <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.load_base) begin
                        r_memAddr <= bus.base_addr;
                    end
                    if (r_count != '0) begin
                        r_memWdata <= r_mem[r_rdPtr];
                        r_memWe    <= 1'b1;
                        r_state    <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    if (bus.mem_ack) begin
                        r_memAddr <= r_memAddr + MEM_AW'(1);
                        if (r_wordsWritten != 16'hFFFF) begin
                            r_wordsWritten <= r_wordsWritten + 16'd1;
                        end
                        if (r_count > CW'(1)) begin
                            r_memWdata <= r_mem[w_rdNext];
                        end else begin
                            r_memWe <= 1'b0;
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: begin
                    r_memWe <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_inst_encoder_writer.sv
// Self-checking bench for inst_encoder_writer: directed scenarios followed by a
// randomized phase, scored against a queue-based model of the encoder/writer.
module tb_inst_encoder_writer;
    localparam int                DEPTH     = 4;
    localparam int                MEM_AW    = 10;
    localparam logic [MEM_AW-1:0] BASE_ADDR = '0;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    inst_encoder_writer_if #(.DEPTH(DEPTH), .MEM_AW(MEM_AW)) bus ();

    inst_encoder_writer #(
        .DEPTH    (DEPTH),
        .MEM_AW   (MEM_AW),
        .BASE_ADDR(BASE_ADDR)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]       data;
        logic [MEM_AW-1:0] addr;
        int                cyc;
    } wr_t;

    int                vectors     = 0;
    int                miscompares = 0;
    logic [31:0]       expQ[$];
    wr_t               writes[$];
    logic [MEM_AW-1:0] expAddr     = BASE_ADDR;
    int                expWords    = 0;
    logic              expFormErr  = 1'b0;
    int                cycle       = 0;
    int                idleStreak  = 0;

    // Instruction word built arithmetically from field positions.
    function automatic logic [31:0] encode(input logic f, input int op, input int r0,
                                           input int r1, input int r2, input int a);
        longint w;
        w = (longint'(op) << 29) + (longint'(r0) << 24) + (longint'(r1) << 19)
          + (f ? longint'(a) : (longint'(r2) << 14));
        return w[31:0];
    endfunction

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic checkOutput();
        chk("fifo_count", 32'(bus.fifo_count), 32'(expQ.size()));
        chk("in_ready", 32'(bus.in_ready), 32'(expQ.size() < DEPTH));
        chk("words_written", 32'(bus.words_written), 32'(expWords));
        chk("form_err", 32'(bus.form_err), 32'(expFormErr));
        chk("mem_addr", 32'(bus.mem_addr), 32'(expAddr));
        if (expQ.size() == 0) begin
            chk("we_when_empty", 32'(bus.mem_we), 32'd0);
        end else if (bus.mem_we) begin
            chk("head_data", bus.mem_wdata, expQ[0]);
        end
        if (expQ.size() != 0 && !bus.mem_we) idleStreak++;
        else idleStreak = 0;
        chk("write_start_delay", 32'(idleStreak <= 1), 32'd1);
    endtask

    task automatic applyStimulus(input logic valid, input logic f, input int op, input int r0,
                                 input int r1, input int r2, input int a, input logic load,
                                 input int base, input logic ack, output logic accepted);
        logic              preWe;
        logic [31:0]       preData;
        logic [MEM_AW-1:0] preAddr;
        int                preSize;
        bus.in_valid   = valid;
        bus.form       = f;
        bus.opcode     = 3'(op);
        bus.reg_addr_0 = 5'(r0);
        bus.reg_addr_1 = 5'(r1);
        bus.reg_addr_2 = 5'(r2);
        bus.addr       = 15'(a);
        bus.load_base  = load;
        bus.base_addr  = MEM_AW'(base);
        bus.mem_ack    = ack;
        #1;
        preWe    = bus.mem_we;
        preData  = bus.mem_wdata;
        preAddr  = bus.mem_addr;
        preSize  = expQ.size();
        accepted = valid && (preSize < DEPTH);
        @(posedge clk);
        cycle++;
        #1;
        if (preWe && ack && expQ.size() > 0) begin
            chk("write_data", preData, expQ.pop_front());
            chk("write_addr", 32'(preAddr), 32'(expAddr));
            writes.push_back('{preData, preAddr, cycle});
            expAddr = expAddr + MEM_AW'(1);
            if (expWords < 65535) expWords++;
        end
        if (preWe && !ack) begin
            chk("hold_we", 32'(bus.mem_we), 32'd1);
            chk("hold_data", bus.mem_wdata, preData);
            chk("hold_addr", 32'(bus.mem_addr), 32'(preAddr));
        end
        if (load && !preWe) expAddr = MEM_AW'(base);
        if (accepted) begin
            expQ.push_back(encode(f, op, r0, r1, r2, a));
            if (f && r2 != 0) expFormErr = 1'b1;
            if (preSize == 0) chk("min_latency", 32'(bus.mem_we), 32'd0);
        end
        checkOutput();
    endtask

    task automatic idle(input logic ack, input int n);
        logic acc;
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, ack, acc);
    endtask

    task automatic doReset(input logic ack);
        rst_n          = 1'b0;
        bus.in_valid   = 1'b0;
        bus.load_base  = 1'b0;
        bus.mem_ack    = ack;
        @(posedge clk);
        cycle++;
        #1;
        expQ.delete();
        writes.delete();
        expAddr    = BASE_ADDR;
        expWords   = 0;
        expFormErr = 1'b0;
        idleStreak = 0;
        chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
        chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
        checkOutput();
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic        acc;
        logic [31:0] words3[5];
        logic [31:0] d;
        int          waitCnt;

        bus.form = 0; bus.opcode = 0; bus.reg_addr_0 = 0; bus.reg_addr_1 = 0;
        bus.reg_addr_2 = 0; bus.addr = 0; bus.base_addr = 0;
        doReset(1'b0);

        $display("[TB] single register-form word");
        applyStimulus(1, 0, 7, 2, 1, 3, 0, 0, 0, 1, acc);
        idle(1, 4);
        chk("t1_nwrites", 32'(writes.size()), 32'd1);
        if (writes.size() >= 1) begin
            chk("t1_data", writes[0].data, 32'hE208C000);
            chk("t1_addr", 32'(writes[0].addr), 32'd0);
        end

        $display("[TB] back-to-back address-form and register-form words");
        doReset(1'b1);
        applyStimulus(1, 1, 3, 1, 3, 0, 4, 0, 0, 1, acc);
        applyStimulus(1, 0, 1, 3, 0, 0, 0, 0, 0, 1, acc);
        idle(1, 4);
        chk("t2_nwrites", 32'(writes.size()), 32'd2);
        if (writes.size() >= 2) begin
            chk("t2_data0", writes[0].data, 32'h61180004);
            chk("t2_data1", writes[1].data, 32'h23000000);
            chk("t2_addr1", 32'(writes[1].addr), 32'd1);
            chk("t2_consecutive", 32'(writes[1].cyc - writes[0].cyc), 32'd1);
        end

        $display("[TB] backpressure with a full FIFO");
        doReset(1'b0);
        for (int i = 0; i < 5; i++) words3[i] = encode(0, i + 1, i, 31 - i, i + 2, 0);
        for (int i = 0; i < 4; i++) applyStimulus(1, 0, i + 1, i, 31 - i, i + 2, 0, 0, 0, 0, acc);
        chk("t3_ready_low", 32'(bus.in_ready), 32'd0);
        for (int i = 0; i < 3; i++) applyStimulus(1, 0, 5, 4, 27, 6, 0, 0, 0, 0, acc);
        acc = 1'b0;
        waitCnt = 0;
        while (!acc && waitCnt < 10) begin
            applyStimulus(1, 0, 5, 4, 27, 6, 0, 0, 0, 1, acc);
            waitCnt++;
        end
        chk("t3_fifth_accepted", 32'(acc), 32'd1);
        idle(1, 8);
        chk("t3_nwrites", 32'(writes.size()), 32'd5);
        if (writes.size() >= 5) begin
            for (int i = 0; i < 5; i++) begin
                chk("t3_order_data", writes[i].data, words3[i]);
                chk("t3_order_addr", 32'(writes[i].addr), 32'(i));
            end
        end

        $display("[TB] base address load, wrap and in-flight protection");
        doReset(1'b1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 'h3FE, 1, acc);
        for (int i = 0; i < 3; i++) applyStimulus(1, 0, 2, i, i, i, 0, 0, 0, 1, acc);
        idle(1, 6);
        chk("t4_nwrites", 32'(writes.size()), 32'd3);
        if (writes.size() >= 3) begin
            chk("t4_addr0", 32'(writes[0].addr), 32'h3FE);
            chk("t4_addr1", 32'(writes[1].addr), 32'h3FF);
            chk("t4_addr2", 32'(writes[2].addr), 32'h000);
        end
        applyStimulus(1, 0, 6, 9, 10, 11, 0, 0, 0, 0, acc);
        idle(0, 2);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 'h155, 0, acc);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 'h155, 0, acc);
        chk("t4_addr_kept", 32'(bus.mem_addr), 32'h001);
        idle(1, 3);
        applyStimulus(1, 1, 4, 1, 2, 0, 'h7FFF, 0, 0, 1, acc);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 'h200, 1, acc);
        idle(1, 3);
        if (writes.size() >= 1) chk("t4_load_on_start", 32'(writes[writes.size() - 1].addr), 32'h200);

        $display("[TB] address form with nonzero register field 2");
        applyStimulus(1, 1, 5, 7, 8, 5, 'h1234, 0, 0, 1, acc);
        idle(1, 3);
        chk("t5_form_err", 32'(bus.form_err), 32'd1);
        if (writes.size() >= 1) begin
            d = writes[writes.size() - 1].data;
            chk("t5_gap_bits", 32'(d[18:15]), 32'd0);
        end
        applyStimulus(1, 0, 1, 1, 1, 1, 0, 0, 0, 1, acc);
        idle(1, 3);

        $display("[TB] reset during an active write");
        applyStimulus(1, 0, 3, 3, 3, 3, 0, 0, 0, 0, acc);
        applyStimulus(1, 0, 4, 4, 4, 4, 0, 0, 0, 0, acc);
        idle(0, 1);
        chk("t6_writing", 32'(bus.mem_we), 32'd1);
        doReset(1'b0);
        idle(1, 4);
        chk("t6_no_writes", 32'(writes.size()), 32'd0);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 400; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          int'($urandom_range(0, 7)), int'($urandom_range(0, 31)),
                          int'($urandom_range(0, 31)),
                          ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 31)) : 0,
                          int'($urandom_range(0, 32767)), 1'($urandom_range(0, 19) == 0),
                          int'($urandom_range(0, 1023)), 1'($urandom_range(0, 9) < 7), acc);
        end
        idle(1, 10);
        chk("t7_drained", 32'(bus.fifo_count), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
